aes_controller: RTL and testbench

- Main FSM of the AHB-Lite AES encryption slave.
- Accepts a write transfer, sequences key load and data load, then runs the AES-128 round pipeline through per-stage enable/finished handshakes.
- Holds the ciphertext until a read transfer collects it.
- Drives the AHB HREADYOUT/HRESP-error signalling and exports the current round number to the datapath.

---
 rtl/aes_ctrl_pkg.sv | 25 ++
 rtl/aes_round_counter.sv | 46 ++++
 rtl/aes_controller.sv | 208 ++++++++++++++++++++
 tb/tb_aes_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES encryption slave controller.
//   state_t        : controller FSM state encoding
//   AES128_ROUNDS  : final round index for a 128-bit key schedule
//   AES256_ROUNDS  : final round index for a 256-bit key schedule
package aes_ctrl_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  typedef enum logic [3:0] {
    IDLE,
    READ_KEY,
    READ_DATA,
    ADD_ROUND,
    KEY_EXP,
    SUB_BYTES,
    SHIFT_ROWS,
    MIX_COL,
    DONE,
    WRITE_OUT,
    ERR1,
    ERR2
  } state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Round counter for the AES controller.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active-high
//   clr_i     : clear count to 0 (wins over inc_i)
//   inc_i     : advance count by one, saturating at LAST_ROUND
//   count_o   : current round number
//   is_last_o : count_o equals LAST_ROUND
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter logic [3:0] LAST_ROUND = AES128_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] count_o,
  output logic       is_last_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (inc_i && (count_q != LAST_ROUND)) begin
      // Saturate at the final round; the count never wraps.
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign is_last_o = (count_q == LAST_ROUND);

endmodule

// File: rtl/aes_controller.sv
// Main FSM of the AHB-Lite AES encryption slave.
// Sequences key load, plaintext load and the round pipeline through
// per-stage enable/finished handshakes, holds the ciphertext until a read
// collects it, and drives HREADYOUT / error-response signalling.
// Configuration macro: AES256_EN -- 14-round schedule and a two-beat key load.
// Ports:
//   clk, n_rst          : clock; asynchronous reset, active-high despite name
//   addrMatch, HSELx    : address decode hit, slave select
//   mWrite, mRead       : decoded write / read request
//   dataReady           : bus word captured by the datapath
//   invalid             : illegal transfer detected
//   *_finished          : per-stage completion levels from the datapath
//   HREADYOUT           : AHB ready
//   *_enable            : one-hot stage enables to the datapath
//   hresp_error         : AHB error response
//   roundnum            : current round, 0..LAST_ROUND
module aes_controller
  import aes_ctrl_pkg::*;
#(
`ifdef AES256_EN
  parameter logic [3:0] LAST_ROUND = AES256_ROUNDS
`else
  parameter logic [3:0] LAST_ROUND = AES128_ROUNDS
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       addrMatch,
  input  logic       HSELx,
  input  logic       mWrite,
  input  logic       mRead,
  input  logic       dataReady,
  input  logic       invalid,
  input  logic       keyexp_finished,
  input  logic       sbytes_finished,
  input  logic       srows_finished,
  input  logic       mcol_finished,
  input  logic       around_finished,
  output logic       HREADYOUT,
  output logic       readk_enable,
  output logic       read_enable,
  output logic       write_enable,
  output logic       keyexp_enable,
  output logic       sbytes_enable,
  output logic       srows_enable,
  output logic       mcol_enable,
  output logic       around_enable,
  output logic       hresp_error,
  output logic [3:0] roundnum
);

  state_t state_q;
  state_t state_d;
  logic   rnd_clr;
  logic   rnd_inc;
  logic   rnd_last;

`ifdef AES256_EN
  // Set after the first key half has been captured.
  logic key_half_q;
  logic key_half_d;
`endif

  aes_round_counter #(
    .LAST_ROUND(LAST_ROUND)
  ) u_round_counter (
    .clk      (clk),
    .rst      (n_rst),
    .clr_i    (rnd_clr),
    .inc_i    (rnd_inc),
    .count_o  (roundnum),
    .is_last_o(rnd_last)
  );

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef AES256_EN
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      key_half_q <= 1'b0;
    end else begin
      key_half_q <= key_half_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    rnd_clr = 1'b0;
    rnd_inc = 1'b0;
`ifdef AES256_EN
    key_half_d = key_half_q;
`endif
    // An illegal transfer aborts any active operation ahead of all else.
    if (invalid && (state_q != IDLE) && (state_q != ERR1) && (state_q != ERR2)) begin
      state_d = ERR1;
    end else begin
      case (state_q)
        IDLE: begin
          if (HSELx && addrMatch && mWrite) begin
            state_d = READ_KEY;
            rnd_clr = 1'b1;
`ifdef AES256_EN
            key_half_d = 1'b0;
`endif
          end else if (HSELx && !addrMatch) begin
            state_d = ERR1;
          end
        end
        READ_KEY: begin
          if (dataReady) begin
`ifdef AES256_EN
            if (!key_half_q) begin
              key_half_d = 1'b1;
            end else begin
              state_d = READ_DATA;
            end
`else
            state_d = READ_DATA;
`endif
          end
        end
        READ_DATA: begin
          if (dataReady) state_d = ADD_ROUND;
        end
        ADD_ROUND: begin
          if (around_finished) begin
            if (rnd_last) begin
              state_d = DONE;
            end else begin
              rnd_inc = 1'b1;
              state_d = KEY_EXP;
            end
          end
        end
        KEY_EXP: begin
          if (keyexp_finished) state_d = SUB_BYTES;
        end
        SUB_BYTES: begin
          if (sbytes_finished) state_d = SHIFT_ROWS;
        end
        SHIFT_ROWS: begin
          // The final round skips MixColumns.
          if (srows_finished) state_d = rnd_last ? ADD_ROUND : MIX_COL;
        end
        MIX_COL: begin
          if (mcol_finished) state_d = ADD_ROUND;
        end
        DONE: begin
          if (HSELx && addrMatch && mRead) begin
            state_d = WRITE_OUT;
          end else if (HSELx && addrMatch && mWrite) begin
            state_d = READ_KEY;
            rnd_clr = 1'b1;
`ifdef AES256_EN
            key_half_d = 1'b0;
`endif
          end
        end
        WRITE_OUT: state_d = IDLE;
        ERR1:      state_d = ERR2;
        ERR2:      state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    HREADYOUT     = 1'b0;
    readk_enable  = 1'b0;
    read_enable   = 1'b0;
    write_enable  = 1'b0;
    keyexp_enable = 1'b0;
    sbytes_enable = 1'b0;
    srows_enable  = 1'b0;
    mcol_enable   = 1'b0;
    around_enable = 1'b0;
    hresp_error   = 1'b0;
    case (state_q)
      IDLE:       HREADYOUT     = 1'b1;
      READ_KEY:   readk_enable  = 1'b1;
      READ_DATA:  read_enable   = 1'b1;
      ADD_ROUND:  around_enable = 1'b1;
      KEY_EXP:    keyexp_enable = 1'b1;
      SUB_BYTES:  sbytes_enable = 1'b1;
      SHIFT_ROWS: srows_enable  = 1'b1;
      MIX_COL:    mcol_enable   = 1'b1;
      DONE:       HREADYOUT     = 1'b1;
      WRITE_OUT: begin
        write_enable = 1'b1;
        HREADYOUT    = 1'b1;
      end
      ERR1:       hresp_error   = 1'b1;
      ERR2: begin
        hresp_error = 1'b1;
        HREADYOUT   = 1'b1;
      end
      default:    HREADYOUT     = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_aes_controller.sv
module tb_aes_controller;

`ifdef AES256_EN
  localparam int LR       = 14;
  localparam int KEYLOADS = 2;
`else
  localparam int LR       = 10;
  localparam int KEYLOADS = 1;
`endif

  // Output vector: {HREADYOUT, hresp_error, readk, read, write,
  //                 keyexp, sbytes, srows, mcol, around}
  localparam logic [9:0] O_IDLE = 10'b10_0000_0000;
  localparam logic [9:0] O_RK   = 10'b00_1000_0000;
  localparam logic [9:0] O_RD   = 10'b00_0100_0000;
  localparam logic [9:0] O_WR   = 10'b10_0010_0000;
  localparam logic [9:0] O_KE   = 10'b00_0001_0000;
  localparam logic [9:0] O_SB   = 10'b00_0000_1000;
  localparam logic [9:0] O_SR   = 10'b00_0000_0100;
  localparam logic [9:0] O_MC   = 10'b00_0000_0010;
  localparam logic [9:0] O_AR   = 10'b00_0000_0001;
  localparam logic [9:0] O_E1   = 10'b01_0000_0000;
  localparam logic [9:0] O_E2   = 10'b11_0000_0000;

  // Handshake selectors: 0 dataReady, 1 around, 2 keyexp, 3 sbytes, 4 srows, 5 mcol
  typedef struct {
    logic [9:0] outs;
    logic [3:0] rnd;
    int         hs;
  } step_t;

  logic clk = 1'b0;
  logic n_rst, addrMatch, HSELx, mWrite, mRead, dataReady, invalid;
  logic keyexp_finished, sbytes_finished, srows_finished, mcol_finished, around_finished;
  logic HREADYOUT, readk_enable, read_enable, write_enable, keyexp_enable;
  logic sbytes_enable, srows_enable, mcol_enable, around_enable, hresp_error;
  logic [3:0] roundnum;

  int n_assert = 0;
  int n_fail   = 0;
  step_t plan[$];
  bit aborted;

  always #5 clk = ~clk;

  aes_controller dut (
    .clk(clk), .n_rst(n_rst), .addrMatch(addrMatch), .HSELx(HSELx),
    .mWrite(mWrite), .mRead(mRead), .dataReady(dataReady), .invalid(invalid),
    .keyexp_finished(keyexp_finished), .sbytes_finished(sbytes_finished),
    .srows_finished(srows_finished), .mcol_finished(mcol_finished),
    .around_finished(around_finished), .HREADYOUT(HREADYOUT),
    .readk_enable(readk_enable), .read_enable(read_enable),
    .write_enable(write_enable), .keyexp_enable(keyexp_enable),
    .sbytes_enable(sbytes_enable), .srows_enable(srows_enable),
    .mcol_enable(mcol_enable), .around_enable(around_enable),
    .hresp_error(hresp_error), .roundnum(roundnum)
  );

  wire [9:0] obs = {HREADYOUT, hresp_error, readk_enable, read_enable, write_enable,
                    keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable};

  task automatic chk(input string tag, input logic [9:0] eo, input logic [3:0] er);
    n_assert++;
    assert (obs === eo)
    else begin
      n_fail++;
      $error("FAIL %s outputs: got %b expected %b", tag, obs, eo);
    end
    n_assert++;
    assert (roundnum === er)
    else begin
      n_fail++;
      $error("FAIL %s roundnum: got %0d expected %0d", tag, roundnum, er);
    end
  endtask

  task automatic clear_in();
    addrMatch = 0; HSELx = 0; mWrite = 0; mRead = 0; dataReady = 0; invalid = 0;
    keyexp_finished = 0; sbytes_finished = 0; srows_finished = 0;
    mcol_finished = 0; around_finished = 0;
  endtask

  task automatic set_hs(input int hs, input logic v);
    case (hs)
      0: dataReady       = v;
      1: around_finished = v;
      2: keyexp_finished = v;
      3: sbytes_finished = v;
      4: srows_finished  = v;
      default: mcol_finished = v;
    endcase
  endtask

  // Expected encryption sequence derived from the round structure of AES:
  // key load(s), plaintext load, whitening AddRoundKey, then per round
  // KeyExp/SubBytes/ShiftRows/[MixColumns]/AddRoundKey, last round without MixColumns.
  task automatic build_plan();
    plan.delete();
    for (int k = 0; k < KEYLOADS; k++) plan.push_back('{O_RK, 4'd0, 0});
    plan.push_back('{O_RD, 4'd0, 0});
    plan.push_back('{O_AR, 4'd0, 1});
    for (int r = 1; r <= LR; r++) begin
      plan.push_back('{O_KE, 4'(r), 2});
      plan.push_back('{O_SB, 4'(r), 3});
      plan.push_back('{O_SR, 4'(r), 4});
      if (r < LR) plan.push_back('{O_MC, 4'(r), 5});
      plan.push_back('{O_AR, 4'(r), 1});
    end
  endtask

  // Called at a negedge with the FSM in the first planned state.
  // While waiting, unrelated handshakes and bus lines are toggled randomly;
  // they must be ignored.
  task automatic run_enc(input bit fast, input int abort_rnd, input int max_steps,
                         output bit was_aborted);
    was_aborted = 0;
    for (int i = 0; i < plan.size() && i < max_steps; i++) begin
      int dly;
      dly = fast ? 0 : int'($urandom_range(0, 3));
      for (int d = 0; d <= dly; d++) begin
        chk($sformatf("step%0d_r%0d", i, plan[i].rnd), plan[i].outs, plan[i].rnd);
        clear_in();
        if (plan[i].outs == O_SB && abort_rnd == int'(plan[i].rnd)) begin
          invalid = 1;
          @(negedge clk);
          clear_in();
          was_aborted = 1;
          return;
        end
        if (d < dly) begin
          for (int k = 0; k < 6; k++)
            if (k != plan[i].hs) set_hs(k, 1'($urandom_range(0, 1)));
          HSELx = 1'($urandom_range(0, 1));
          addrMatch = 1'($urandom_range(0, 1));
          mRead = 1'($urandom_range(0, 1));
          mWrite = 1'($urandom_range(0, 1));
        end else begin
          set_hs(plan[i].hs, 1'b1);
        end
        @(negedge clk);
      end
    end
    clear_in();
  endtask

  task automatic start_op();
    clear_in();
    HSELx = 1; addrMatch = 1; mWrite = 1;
    @(negedge clk);
    clear_in();
  endtask

  initial begin
    clear_in();
    n_rst = 1;
    #1 chk("in_reset", O_IDLE, 4'd0);
    #9 n_rst = 0;
    @(negedge clk);
    chk("after_reset", O_IDLE, 4'd0);

    // invalid in IDLE is ignored
    invalid = 1;
    @(negedge clk);
    clear_in();
    chk("idle_invalid", O_IDLE, 4'd0);

    // First encryption: handshakes answered immediately
    build_plan();
    start_op();
    run_enc(1'b1, -1, 1000, aborted);
    chk("done", O_IDLE, 4'(LR));
    repeat (2) @(negedge clk);
    chk("done_hold", O_IDLE, 4'(LR));
    HSELx = 1; addrMatch = 1; mRead = 1;
    @(negedge clk);
    clear_in();
    chk("write_out", O_WR, 4'(LR));
    @(negedge clk);
    chk("after_write", O_IDLE, 4'(LR));

    // Abort with invalid during SubBytes of round 3
    start_op();
    run_enc(1'b0, 3, 1000, aborted);
    n_assert++;
    assert (aborted === 1'b1)
    else begin
      n_fail++;
      $error("FAIL abort_reached: got %0d expected 1", aborted);
    end
    chk("abort_err1", O_E1, 4'd3);
    @(negedge clk);
    chk("abort_err2", O_E2, 4'd3);
    @(negedge clk);
    chk("abort_idle", O_IDLE, 4'd3);

    // Address miss in IDLE
    HSELx = 1; addrMatch = 0; mWrite = 1'($urandom_range(0, 1));
    @(negedge clk);
    clear_in();
    chk("miss_err1", O_E1, 4'd3);
    @(negedge clk);
    chk("miss_err2", O_E2, 4'd3);
    @(negedge clk);
    chk("miss_idle", O_IDLE, 4'd3);

    // Random-latency encryption, then restart straight from DONE
    start_op();
    run_enc(1'b0, -1, 1000, aborted);
    chk("done2", O_IDLE, 4'(LR));
    HSELx = 1; addrMatch = 1; mWrite = 1;
    @(negedge clk);
    clear_in();
    chk("restart_from_done", O_RK, 4'd0);

    // Mid-encryption asynchronous reset
    run_enc(1'b0, -1, KEYLOADS + 6, aborted);
    #2 n_rst = 1;
    #1 chk("async_reset", O_IDLE, 4'd0);
    @(negedge clk);
    n_rst = 0;
    chk("reset_release", O_IDLE, 4'd0);
    @(negedge clk);
    chk("post_reset_idle", O_IDLE, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
